mvm_sequencer: RTL and testbench
================================

Name: mvm_sequencer

Overview:
Upstream control stage for the vsm vector-scalar multiply-accumulate unit. It turns one input-vector transaction plus a stream of DEPTH weight columns into a full matrix-vector product: y = sum over k of W[:,k] * x[k].
- Drives the vsm reset, enable, a and b pins, one column per accepted beat.
- Waits out the vsm pipeline latency, then captures the accumulated vsm out as the result.
- Presents the result on a valid/ready output port.

Parameters:
SIZE, 3, lanes per vector (rows of W); matches vsm SIZE.
DEPTH, 3, input-vector length = number of weight columns per product (>=1).
VSM_LATENCY, 2, cycles from last vsm_enable beat to final value on vsm_out (>=1).

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
x_valid  in  1  input vector offered.
x_ready  out  1  sequencer can accept input vector.
x  in  8*DEPTH  input vector; element 0 in the most significant byte.
w_valid  in  1  weight column offered.
w_ready  out  1  sequencer can accept weight column.
w_col  in  8*SIZE  weight column; lane 0 in the most significant byte.
vsm_reset  out  1  to vsm reset (active-high).
vsm_enable  out  1  to vsm enable.
vsm_a  out  8*SIZE  to vsm a.
vsm_b  out  8  to vsm b.
vsm_out  in  8*SIZE  from vsm out.
y_valid  out  1  result available.
y_ready  in  1  consumer accepts result.
y  out  8*SIZE  result vector.
busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, col_idx=0, drain count=0, x register=0, y=0, y_valid=0.
  - vsm_reset = ~reset_n | (state==CLEAR), so the vsm is held cleared while reset_n is low.
- States: IDLE, CLEAR, ACCUM, DRAIN, OUTPUT.
- IDLE:
  - x_ready=1; all other handshake outputs 0.
  - On x_valid & x_ready: register x, go to CLEAR.
- CLEAR:
  - Exactly one cycle; vsm_reset=1, col_idx<=0.
  - Next state ACCUM.
- ACCUM:
  - w_ready=1.
  - vsm_enable = w_valid (combinational).
  - vsm_a = w_col (pass-through).
  - vsm_b = x byte col_idx, i.e. x[8*DEPTH-1-8*col_idx -: 8].
  - On w_valid & w_ready: col_idx increments.
  - If col_idx==DEPTH-1 on an accepted beat: go to DRAIN, load drain count with VSM_LATENCY.
  - w_valid low: vsm_enable=0, nothing advances; the vsm holds its accumulator (stall-safe).
- DRAIN:
  - w_ready=0, vsm_enable=0.
  - Drain count decrements once per cycle.
  - In the cycle the count reaches 1: y<=vsm_out, y_valid<=1, go to OUTPUT.
  - The result is therefore taken VSM_LATENCY cycles after the last enable beat.
- OUTPUT:
  - y and y_valid are held stable until y_ready.
  - On y_valid & y_ready: y_valid<=0, go to IDLE.
  - The next x is accepted no earlier than the following cycle; there is no overlap of products.
- Outside ACCUM: vsm_enable=0, vsm_a=0, vsm_b=0.
- Arithmetic: none in this block. Per-lane 8-bit wrap-around is done by the vsm; y is an unmodified copy of vsm_out (except under the optional feature).
- Boundaries:
  - DEPTH=1: ACCUM accepts exactly one beat.
  - A w_valid pulse outside ACCUM is ignored (w_ready=0).
  - x_valid outside IDLE is ignored.
  - Reset mid-ACCUM or mid-DRAIN discards the partial product with no y_valid pulse.
- Total latency with no stalls and y_ready held high: x accept, then 1 CLEAR cycle, DEPTH ACCUM cycles, VSM_LATENCY DRAIN cycles; y_valid rises in the following cycle.

Optional Feature:
- Macro MVM_SEQ_RELU_EN.
- Defined: each 8-bit lane of vsm_out is treated as two's complement; lanes with bit 7 set are replaced by 0x00 when captured into y; other lanes pass unchanged.
- Undefined: y is the raw vsm_out capture.

Test Plan:
- Basic product: x=24'h010203, columns 24'h010407, 24'h020508, 24'h030609 on consecutive cycles, y_ready=1 -> y=24'h0E2032, y_valid high for one cycle, vsm_reset seen for exactly one cycle before the first enable.
- Column stalls: same data with w_valid low for 2 cycles between each column -> vsm_enable low during the gaps, y=24'h0E2032, col_idx unchanged while stalled.
- Output backpressure: hold y_ready=0 for 5 cycles after y_valid -> y stays 24'h0E2032, x_ready=0 and busy=1 throughout; IDLE is entered the cycle after y_ready=1.
- Wrap-around: x=24'h020000, columns 24'h80FF01, 0, 0 -> y=24'h00FE02 (per-lane mod 256).
- Reset mid-operation: pull reset_n low after the second column is accepted -> vsm_reset=1, y_valid=0, state IDLE. A fresh basic-product run afterwards still yields y=24'h0E2032.
- Optional ReLU: x=24'h010000, columns 24'hF01020, 0, 0 -> without MVM_SEQ_RELU_EN y=24'hF01020; with it defined y=24'h001020.

Source files
------------

// File: rtl/mvm_sequencer.sv
// rtl/mvm_sequencer.sv - sequences one x vector and DEPTH weight columns through a vsm MAC into y
// Optional MVM_SEQ_RELU_EN: clamp negative (bit 7 set) result lanes to zero on capture.
module mvm_sequencer #(
    parameter int SIZE        = 3,
    parameter int DEPTH       = 3,
    parameter int VSM_LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                x_valid,
    output logic                x_ready,
    input  logic [8*DEPTH-1:0]  x,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [8*SIZE-1:0]   w_col,
    output logic                vsm_reset,
    output logic                vsm_enable,
    output logic [8*SIZE-1:0]   vsm_a,
    output logic [7:0]          vsm_b,
    input  logic [8*SIZE-1:0]   vsm_out,
    output logic                y_valid,
    input  logic                y_ready,
    output logic [8*SIZE-1:0]   y,
    output logic                busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(VSM_LATENCY + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        OUTPUT
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   col_idx;
    logic [CNT_W-1:0]   drain_cnt;
    logic [8*DEPTH-1:0] x_q;
    logic [8*DEPTH-1:0] x_shift;
    logic [8*SIZE-1:0]  y_capture;
    logic               w_fire;
    logic               last_beat;

`ifdef MVM_SEQ_RELU_EN
    always_comb begin
        y_capture = vsm_out;
        for (int i = 0; i < SIZE; i++) begin
            if (vsm_out[8*i+7]) begin
                y_capture[8*i +: 8] = 8'h00;
            end
        end
    end
`else
    assign y_capture = vsm_out;
`endif

    assign w_fire    = (state == ACCUM) && w_valid;
    assign last_beat = w_fire && (col_idx == IDX_W'(DEPTH - 1));
    // element 0 sits in the top byte, so shift the selected element up to it
    assign x_shift   = x_q << {col_idx, 3'b000};

    always_comb begin
        next_state = state;
        x_ready    = 1'b0;
        w_ready    = 1'b0;
        vsm_enable = 1'b0;
        vsm_a      = '0;
        vsm_b      = '0;
        case (state)
            IDLE: begin
                x_ready = 1'b1;
                if (x_valid) begin
                    next_state = CLEAR;
                end
            end
            CLEAR: begin
                next_state = ACCUM;
            end
            ACCUM: begin
                w_ready    = 1'b1;
                vsm_enable = w_valid;
                vsm_a      = w_col;
                vsm_b      = x_shift[8*DEPTH-1 -: 8];
                if (last_beat) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == CNT_W'(1)) begin
                    next_state = OUTPUT;
                end
            end
            OUTPUT: begin
                if (y_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign vsm_reset = ~reset_n | (state == CLEAR);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            col_idx   <= '0;
            drain_cnt <= '0;
            x_q       <= '0;
            y         <= '0;
            y_valid   <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (x_valid) begin
                        x_q <= x;
                    end
                end
                CLEAR: begin
                    col_idx <= '0;
                end
                ACCUM: begin
                    if (w_fire) begin
                        col_idx <= col_idx + IDX_W'(1);
                    end
                    if (last_beat) begin
                        drain_cnt <= CNT_W'(VSM_LATENCY);
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - CNT_W'(1);
                    // by the time the count is 1 the vsm has finished the last beat
                    if (drain_cnt == CNT_W'(1)) begin
                        y       <= y_capture;
                        y_valid <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_sequencer.sv
// tb/tb_mvm_sequencer.sv - scoreboard bench for mvm_sequencer with a behavioural vsm model
module tb_mvm_sequencer;

    localparam int SIZE        = 3;
    localparam int DEPTH       = 3;
    localparam int VSM_LATENCY = 2;
    localparam int BOUND       = 50;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                x_valid;
    logic                x_ready;
    logic [8*DEPTH-1:0]  x;
    logic                w_valid;
    logic                w_ready;
    logic [8*SIZE-1:0]   w_col;
    logic                vsm_reset;
    logic                vsm_enable;
    logic [8*SIZE-1:0]   vsm_a;
    logic [7:0]          vsm_b;
    logic [8*SIZE-1:0]   vsm_out;
    logic                y_valid;
    logic                y_ready;
    logic [8*SIZE-1:0]   y;
    logic                busy;

    int vectors     = 0;
    int miscompares = 0;
    logic [8*SIZE-1:0] exp_q[$];
    logic [8*SIZE-1:0] acc;

    mvm_sequencer #(.SIZE(SIZE), .DEPTH(DEPTH), .VSM_LATENCY(VSM_LATENCY)) dut (
        .clk(clk), .reset_n(reset_n),
        .x_valid(x_valid), .x_ready(x_ready), .x(x),
        .w_valid(w_valid), .w_ready(w_ready), .w_col(w_col),
        .vsm_reset(vsm_reset), .vsm_enable(vsm_enable), .vsm_a(vsm_a), .vsm_b(vsm_b),
        .vsm_out(vsm_out),
        .y_valid(y_valid), .y_ready(y_ready), .y(y), .busy(busy)
    );

    always #5 clk = ~clk;

    // vsm: accumulate register then output register, two cycles from enable to out
    always @(posedge clk) begin
        if (vsm_reset) begin
            acc     <= '0;
            vsm_out <= '0;
        end else begin
            if (vsm_enable) begin
                for (int i = 0; i < SIZE; i++) begin
                    acc[8*i +: 8] <= acc[8*i +: 8] + 8'(vsm_a[8*i +: 8] * vsm_b);
                end
            end
            vsm_out <= acc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (y_valid && y_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_y", 32'(y), 32'hDEAD_BEEF);
            end else begin
                check("y_result", 32'(y), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_x(input logic [8*DEPTH-1:0] v);
        int n = 0;
        x       = v;
        x_valid = 1'b1;
        @(negedge clk);
        while (!x_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n == BOUND) check("x_timeout", 32'(n), 32'(0));
        @(posedge clk);
        #1 x_valid = 1'b0;
    endtask

    task automatic send_w(input logic [8*SIZE-1:0] col, input logic [7:0] b, input int gap);
        int n = 0;
        w_valid = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            check("stall_enable", 32'(vsm_enable), 32'(0));
            check("stall_col_idx", 32'(vsm_b), 32'(b));
            @(posedge clk);
            #1;
        end
        w_col   = col;
        w_valid = 1'b1;
        @(negedge clk);
        while (!w_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n == BOUND) check("w_timeout", 32'(n), 32'(0));
        check("beat_enable", 32'(vsm_enable), 32'(1));
        check("beat_a", 32'(vsm_a), 32'(col));
        check("beat_b", 32'(vsm_b), 32'(b));
        @(posedge clk);
        #1 w_valid = 1'b0;
    endtask

    task automatic wait_y();
        int n = 0;
        @(negedge clk);
        while (!(y_valid && y_ready) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n == BOUND) check("y_timeout", 32'(n), 32'(0));
        @(posedge clk);
        #1;
        check("y_valid_drop", 32'(y_valid), 32'(0));
        check("idle_after_y", 32'(busy), 32'(0));
    endtask

    task automatic run(input logic [23:0] xv, input logic [23:0] c0, input logic [23:0] c1,
                       input logic [23:0] c2, input int gap, input logic [23:0] expy);
        exp_q.push_back(expy);
        send_x(xv);
        check("clear_reset", 32'(vsm_reset), 32'(1));
        check("clear_busy", 32'(busy), 32'(1));
        send_w(c0, xv[23:16], 0);
        send_w(c1, xv[15:8], gap);
        send_w(c2, xv[7:0], gap);
    endtask

    initial begin
        reset_n = 1'b0;
        x_valid = 1'b0;
        x       = '0;
        w_valid = 1'b0;
        w_col   = '0;
        y_ready = 1'b1;
        #2;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_y_valid", 32'(y_valid), 32'(0));
        check("rst_y", 32'(y), 32'(0));
        check("rst_vsm_reset", 32'(vsm_reset), 32'(1));
        check("rst_x_ready", 32'(x_ready), 32'(1));
        check("rst_w_ready", 32'(w_ready), 32'(0));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1 check("run_vsm_reset", 32'(vsm_reset), 32'(0));

        // weight column offered while idle must be ignored
        w_col   = 24'h111111;
        w_valid = 1'b1;
        @(negedge clk);
        check("idle_w_ready", 32'(w_ready), 32'(0));
        check("idle_enable", 32'(vsm_enable), 32'(0));
        @(posedge clk);
        #1 w_valid = 1'b0;

        run(24'h010203, 24'h010407, 24'h020508, 24'h030609, 0, 24'h0E2032);
        wait_y();

        run(24'h010203, 24'h010407, 24'h020508, 24'h030609, 2, 24'h0E2032);
        wait_y();

        y_ready = 1'b0;
        run(24'h010203, 24'h010407, 24'h020508, 24'h030609, 0, 24'h0E2032);
        begin
            int n = 0;
            @(negedge clk);
            while (!y_valid && n < BOUND) begin
                @(negedge clk);
                n++;
            end
            if (n == BOUND) check("bp_timeout", 32'(n), 32'(0));
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_y", 32'(y), 32'h0E2032);
            check("bp_y_valid", 32'(y_valid), 32'(1));
            check("bp_x_ready", 32'(x_ready), 32'(0));
            check("bp_busy", 32'(busy), 32'(1));
            @(negedge clk);
        end
        @(posedge clk);
        #1 y_ready = 1'b1;
        wait_y();

        run(24'h020000, 24'h80FF01, 24'h000000, 24'h000000, 0, 24'h00FE02);
        wait_y();

        // abort after the second column: no result may appear
        send_x(24'h010203);
        send_w(24'h010407, 8'h01, 0);
        send_w(24'h020508, 8'h02, 0);
        reset_n = 1'b0;
        #1;
        check("abort_vsm_reset", 32'(vsm_reset), 32'(1));
        check("abort_y_valid", 32'(y_valid), 32'(0));
        check("abort_idle", 32'(busy), 32'(0));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_y", 32'(y_valid), 32'(0));

        run(24'h010203, 24'h010407, 24'h020508, 24'h030609, 0, 24'h0E2032);
        wait_y();

`ifdef MVM_SEQ_RELU_EN
        run(24'h010000, 24'hF01020, 24'h000000, 24'h000000, 0, 24'h001020);
`else
        run(24'h010000, 24'hF01020, 24'h000000, 24'h000000, 0, 24'hF01020);
`endif
        wait_y();

        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1);
    end

endmodule
